// File: rtl/ins_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the default load address and capacity, the word/byte geometry, the FSM
// state encoding and a helper that left-justifies a partially filled word.
package ins_mem_loader_pkg;

   localparam logic [31:0] BASE_ADDR_DEF  = 32'h0000_0100;
   localparam int unsigned MAX_WORDS_DEF  = 256;

   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned COUNT_W        = 9;
   localparam logic [31:0] ADDR_STEP      = 32'd4;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCollect = 2'd1,
      StWrite   = 2'd2,
      StDone    = 2'd3
   } state_e;

   // Bytes arrive into the low end of the shift register; a short final word
   // is moved to the top so the first byte always lands in bits [31:24].
   function automatic logic [WORD_W-1:0] left_justify(input logic [WORD_W-1:0] raw,
                                                      input logic [2:0]        nbytes);
      logic [WORD_W-1:0] res;
      case (nbytes)
         3'd1:    res = {raw[7:0], 24'h0};
         3'd2:    res = {raw[15:0], 16'h0};
         3'd3:    res = {raw[23:0], 8'h0};
         3'd4:    res = raw;
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ins_mem_loader_word_packer.sv
// Big-endian byte-to-word packer.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   clear       drop any partial word (byte count and last flag to zero)
//   in_byte     stream byte, shifted in when shift=1
//   shift       a byte transfer happens this cycle
//   last        the transferred byte is the final byte of the image
//   word        collected word, left-justified and zero-filled
//   word_ready  this cycle's transfer completes a word (4th byte or last)
//   word_last   the collected word ended with the last byte
module ins_mem_loader_word_packer
   import ins_mem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [BYTE_W-1:0] in_byte,
   input  logic              shift,
   input  logic              last,
   output logic [WORD_W-1:0] word,
   output logic              word_ready,
   output logic              word_last
);

   logic [WORD_W-1:0] sh_q;
   logic [2:0]        count_q;
   logic              last_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_q    <= '0;
         count_q <= '0;
         last_q  <= 1'b0;
      end else if (clear) begin
         sh_q    <= '0;
         count_q <= '0;
         last_q  <= 1'b0;
      end else if (shift) begin
         sh_q    <= {sh_q[WORD_W-BYTE_W-1:0], in_byte};
         count_q <= count_q + 3'd1;
         last_q  <= last;
      end
   end

   // Combinational so the FSM leaves COLLECT on the same edge as the final byte.
   assign word_ready = shift & ((count_q == 3'(BYTES_PER_WORD - 1)) | last);
   assign word       = left_justify(sh_q, count_q);
   assign word_last  = last_q;

endmodule

// File: rtl/ins_mem_loader.sv
// Instruction-memory loader: packs a valid/ready byte stream big-endian into
// 32-bit words and writes them at consecutive addresses from BASE_ADDR.
// Ports:
//   CLK, Reset       clock, synchronous active-low reset
//   Start            begin a load (honoured only when idle or done)
//   InByte/InValid/InLast/InReady   byte stream handshake
//   IWE/IWAddr/IWData               instruction-memory write port
//   WordCount        words written since Start
//   Busy/Done/Err    load status; Err flags truncation at MAX_WORDS
module ins_mem_loader
   import ins_mem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
   parameter int unsigned MAX_WORDS = MAX_WORDS_DEF
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic               Start,
   input  logic [BYTE_W-1:0]  InByte,
   input  logic               InValid,
   input  logic               InLast,
   output logic               InReady,
   output logic               IWE,
   output logic [31:0]        IWAddr,
   output logic [WORD_W-1:0]  IWData,
   output logic [COUNT_W-1:0] WordCount,
   output logic               Busy,
   output logic               Done,
   output logic               Err
);

   localparam logic [COUNT_W-1:0] MAX_WORDS_W = COUNT_W'(MAX_WORDS);

   state_e               state_q, state_d;
   logic [31:0]          addr_q, addr_d;
   logic [COUNT_W-1:0]   wcount_q, wcount_d, wcount_inc;
   logic                 err_q, err_d;

   logic                 transfer;
   logic                 pk_clear;
   logic [WORD_W-1:0]    pk_word;
   logic                 pk_ready;
   logic                 pk_last;

   ins_mem_loader_word_packer u_packer (
      .clk        (CLK),
      .rst_n      (Reset),
      .clear      (pk_clear),
      .in_byte    (InByte),
      .shift      (transfer),
      .last       (InLast),
      .word       (pk_word),
      .word_ready (pk_ready),
      .word_last  (pk_last)
   );

   assign InReady    = (state_q == StCollect);
   assign transfer   = InValid & InReady;
   assign wcount_inc = wcount_q + COUNT_W'(1);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wcount_d = wcount_q;
      err_d    = err_q;
      pk_clear = 1'b0;
      case (state_q)
         StIdle, StDone: begin
            if (Start) begin
               state_d  = StCollect;
               addr_d   = BASE_ADDR;
               wcount_d = '0;
               err_d    = 1'b0;
               pk_clear = 1'b1;
            end
         end
         StCollect: begin
            if (pk_ready) state_d = StWrite;
         end
         StWrite: begin
            addr_d   = addr_q + ADDR_STEP;
            wcount_d = wcount_inc;
            pk_clear = 1'b1;
            // A last byte wins over the capacity check, so an image that
            // exactly fills memory is not flagged as truncated.
            if (pk_last) begin
               state_d = StDone;
               err_d   = 1'b0;
            end else if (wcount_inc == MAX_WORDS_W) begin
               state_d = StDone;
               err_d   = 1'b1;
            end else begin
               state_d = StCollect;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state_q  <= StIdle;
         addr_q   <= BASE_ADDR;
         wcount_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wcount_q <= wcount_d;
         err_q    <= err_d;
      end
   end

   assign IWE       = (state_q == StWrite);
   assign IWAddr    = addr_q;
   assign IWData    = pk_word;
   assign WordCount = wcount_q;
   assign Busy      = (state_q == StCollect) | (state_q == StWrite);
   assign Done      = (state_q == StDone);
   assign Err       = err_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
module tb_ins_mem_loader;

   localparam int unsigned MAXW = 4;
   localparam logic [31:0] BASE = 32'h100;

   logic        CLK = 1'b0;
   logic        Reset = 1'b0;
   logic        Start = 1'b0;
   logic [7:0]  InByte = 8'h00;
   logic        InValid = 1'b0;
   logic        InLast = 1'b0;
   logic        InReady, IWE, Busy, Done, Err;
   logic [31:0] IWAddr, IWData;
   logic [8:0]  WordCount;

   ins_mem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .Start     (Start),
      .InByte    (InByte),
      .InValid   (InValid),
      .InLast    (InLast),
      .InReady   (InReady),
      .IWE       (IWE),
      .IWAddr    (IWAddr),
      .IWData    (IWData),
      .WordCount (WordCount),
      .Busy      (Busy),
      .Done      (Done),
      .Err       (Err)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic        ready_s = 1'b0, iwe_s = 1'b0, prev_iwe = 1'b0;
   logic        busy_s = 1'b0, done_s = 1'b0, err_s = 1'b0;
   logic [31:0] addr_s = '0, data_s = '0;
   logic [8:0]  wc_s = '0;

   logic [7:0]  img[$];
   logic [63:0] got[$];
   logic [63:0] exp_w[$];
   int          exp_nw;
   logic        exp_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample outputs just after the edge, log writes, police IWE.
   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
      prev_iwe = iwe_s;
      ready_s  = InReady;
      iwe_s    = IWE;
      busy_s   = Busy;
      done_s   = Done;
      err_s    = Err;
      addr_s   = IWAddr;
      data_s   = IWData;
      wc_s     = WordCount;
      if (iwe_s) begin
         got.push_back({addr_s, data_s});
         chk("iwe_width", {63'd0, prev_iwe}, 64'd0);
         chk("iwe_only_in_write", {61'd0, busy_s, ready_s, done_s}, 64'd4);
      end
   endtask

   // Reference: split the image into 4-byte big-endian words, stop at the
   // last byte or at capacity, whichever comes first.
   task automatic build_expected(input logic has_last);
      int n;
      int need;
      logic [31:0] w;
      n    = img.size();
      need = (n + 3) / 4;
      exp_w.delete();
      if (has_last && need <= int'(MAXW)) begin
         exp_nw  = need;
         exp_err = 1'b0;
      end else begin
         exp_nw  = MAXW;
         exp_err = 1'b1;
      end
      for (int k = 0; k < exp_nw; k++) begin
         w = '0;
         for (int j = 0; j < 4; j++)
            if (4 * k + j < n) w[31 - 8 * j -: 8] = img[4 * k + j];
         exp_w.push_back({BASE + 32'(4 * k), w});
      end
   endtask

   task automatic start_load();
      Start = 1'b1;
      tick();
      Start = 1'b0;
      chk("ready_after_start", {63'd0, ready_s}, 64'd1);
      chk("busy_after_start", {63'd0, busy_s}, 64'd1);
      chk("done_cleared", {63'd0, done_s}, 64'd0);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
      bit acc;
      int budget;
      InValid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      InByte  = b;
      InValid = 1'b1;
      InLast  = last;
      budget  = 0;
      acc     = 1'b0;
      while (!acc && !done_s && budget < 50) begin
         acc = ready_s;
         tick();
         budget++;
      end
      if (budget >= 50) chk("send_timeout", 64'd1, 64'd0);
      InValid = 1'b0;
      InLast  = 1'b0;
   endtask

   task automatic wait_done();
      int budget;
      budget = 0;
      while (!done_s && budget < 100) begin
         tick();
         budget++;
      end
      chk("done_reached", {63'd0, done_s}, 64'd1);
   endtask

   task automatic run_image(input logic has_last, input int max_gap, input logic check_timing);
      int n;
      int c0;
      n = img.size();
      got.delete();
      build_expected(has_last);
      // First byte is already offered alongside Start; it must not be taken then.
      InByte  = img[0];
      InValid = 1'b1;
      InLast  = has_last && (n == 1);
      start_load();
      c0 = cyc;
      for (int i = 0; i < n; i++)
         send_byte(img[i], has_last && (i == n - 1), (i == 0) ? 0 : int'($urandom_range(max_gap, 0)));
      wait_done();
      chk("nwrites", 64'(got.size()), 64'(exp_nw));
      for (int k = 0; k < exp_nw && k < got.size(); k++)
         chk($sformatf("write%0d", k), got[k], exp_w[k]);
      chk("err", {63'd0, err_s}, {63'd0, exp_err});
      chk("wordcount", {55'd0, wc_s}, 64'(exp_nw));
      chk("final_addr", {32'd0, addr_s}, {32'd0, BASE + 32'(4 * exp_nw)});
      chk("busy_done", {62'd0, busy_s, ready_s}, 64'd0);
      if (check_timing) chk("cycles", 64'(cyc - c0), 64'(5 * exp_nw));
   endtask

   task automatic load_test2();
      img.delete();
      img = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h04};
   endtask

   initial begin
      int n;

      // 1: reset overrides Start and InValid
      Start   = 1'b1;
      InValid = 1'b1;
      tick();
      tick();
      chk("rst_iwe", {63'd0, iwe_s}, 64'd0);
      chk("rst_ready", {63'd0, ready_s}, 64'd0);
      chk("rst_busy", {63'd0, busy_s}, 64'd0);
      chk("rst_done", {63'd0, done_s}, 64'd0);
      chk("rst_err", {63'd0, err_s}, 64'd0);
      chk("rst_addr", {32'd0, addr_s}, 64'h100);
      chk("rst_wc", {55'd0, wc_s}, 64'd0);
      chk("rst_data", {32'd0, data_s}, 64'd0);
      Start   = 1'b0;
      InValid = 1'b0;
      Reset   = 1'b1;
      tick();

      // 2: two full words, back-to-back
      load_test2();
      run_image(1'b1, 0, 1'b1);
      chk("t2_word0", got.size() > 0 ? got[0] : 64'd0, 64'h0000_0100_2001_0005);
      chk("t2_word1", got.size() > 1 ? got[1] : 64'd0, 64'h0000_0104_8C22_0004);

      // 3: short last word is zero-filled
      img.delete();
      img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
      run_image(1'b1, 0, 1'b0);
      chk("t3_word1", got.size() > 1 ? got[1] : 64'd0, 64'h0000_0104_EEFF_0000);

      // 4: same stream with random valid gaps
      for (int r = 0; r < 3; r++) begin
         load_test2();
         run_image(1'b1, 3, 1'b0);
      end

      // 5: 20 bytes without last, capacity 4 words
      img.delete();
      for (int i = 0; i < 20; i++) img.push_back(8'($urandom));
      run_image(1'b0, 1, 1'b0);
      InValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("excess_not_ready", {63'd0, ready_s}, 64'd0);
      end
      InValid = 1'b0;
      chk("excess_no_write", 64'(got.size()), 64'(MAXW));

      // exact fill with last: no error
      img.delete();
      for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
      run_image(1'b1, 2, 1'b0);

      // 6: reset mid-load, then reload from base
      got.delete();
      InByte  = 8'h20;
      InValid = 1'b1;
      start_load();
      send_byte(8'h20, 1'b0, 0);
      send_byte(8'h01, 1'b0, 0);
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      chk("midrst_busy", {63'd0, busy_s}, 64'd0);
      chk("midrst_ready", {63'd0, ready_s}, 64'd0);
      chk("midrst_addr", {32'd0, addr_s}, 64'h100);
      chk("midrst_wc", {55'd0, wc_s}, 64'd0);
      tick();
      tick();
      chk("midrst_no_write", 64'(got.size()), 64'd0);
      load_test2();
      run_image(1'b1, 0, 1'b1);

      // random images with last, lengths spanning short, exact fill and overflow
      for (int r = 0; r < 10; r++) begin
         n = int'($urandom_range(20, 1));
         img.delete();
         for (int i = 0; i < n; i++) img.push_back(8'($urandom));
         run_image(1'b1, 2, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
